// File: rtl/alu_pkg.sv
// Shared definitions for the ALU / multiply-divide unit.
//   aluop_e        : 5-bit operation codes (0..10 single-cycle, 16..23 iterative)
//   state_e        : controller states
//   is_multicycle  : true for the iterative multiply/divide codes
//   op_a_signed    : num1 is treated as two's complement for this op
//   op_b_signed    : num2 is treated as two's complement for this op
package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_XOR    = 5'd2,
    OP_OR     = 5'd3,
    OP_AND    = 5'd4,
    OP_SLT    = 5'd5,
    OP_SLL    = 5'd6,
    OP_SRL    = 5'd7,
    OP_SRA    = 5'd8,
    OP_SLTU   = 5'd9,
    OP_EQ     = 5'd10,
    OP_MUL    = 5'd16,
    OP_MULH   = 5'd17,
    OP_MULHSU = 5'd18,
    OP_MULHU  = 5'd19,
    OP_DIV    = 5'd20,
    OP_DIVU   = 5'd21,
    OP_REM    = 5'd22,
    OP_REMU   = 5'd23
  } aluop_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Codes 16..23 share the prefix 2'b10.
  function automatic logic is_multicycle(input logic [4:0] op);
    return op[4:3] == 2'b10;
  endfunction

  function automatic logic op_a_signed(input logic [4:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_b_signed(input logic [4:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/alu_basic.sv
// Combinational single-cycle ALU.
//   op_i : operation code (alu_pkg encoding); unknown codes give 0
//   a_i  : first operand
//   b_i  : second operand; only b_i[SHW-1:0] is used as a shift amount
//   y_o  : result; compares return 0/1 zero-extended
module alu_basic import alu_pkg::*; #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic [4:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] y_o
);

  logic [SHW-1:0] shamt;
  assign shamt = b_i[SHW-1:0];

  always_comb begin
    y_o = '0;
    case (op_i)
      OP_ADD:  y_o = a_i + b_i;
      OP_SUB:  y_o = a_i - b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_AND:  y_o = a_i & b_i;
      OP_SLT:  y_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      OP_SLL:  y_o = a_i << shamt;
      OP_SRL:  y_o = a_i >> shamt;
      OP_SRA:  y_o = $signed(a_i) >>> shamt;
      OP_SLTU: y_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
      OP_EQ:   y_o = {{(XLEN-1){1'b0}}, (a_i == b_i)};
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_mdu.sv
// ALU with iterative multiply/divide behind a valid/ready handshake.
//   clk, rst           : clock, synchronous active-high reset
//   in_valid/in_ready  : request handshake (ready only in IDLE)
//   aluop, num1, num2  : request, latched on acceptance
//   out_valid/out_ready: result handshake (valid only in DONE)
//   res                : result, held until taken
//
// state | meaning
// IDLE  | waiting for a request
// EXEC  | one multiply/divide bit per cycle, XLEN cycles
// DONE  | res valid, held until out_ready
module alu_mdu import alu_pkg::*; #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      aluop,
  input  logic [XLEN-1:0] num1,
  input  logic [XLEN-1:0] num2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] res
);

  localparam int CW = $clog2(XLEN) + 1;

  state_e          state_q, state_d;
  logic [4:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [XLEN-1:0] basic_y;

  alu_basic #(.XLEN(XLEN), .SHW(SHW)) u_basic (
    .op_i (aluop),
    .a_i  (num1),
    .b_i  (num2),
    .y_o  (basic_y)
  );

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn && v[XLEN-1]) ? -v : v;
  endfunction

  logic [XLEN-1:0] in_amag, in_bmag, amag, bmag;
  assign in_amag = mag(num1, op_a_signed(aluop));
  assign in_bmag = mag(num2, op_b_signed(aluop));
  assign amag    = mag(a_q, op_a_signed(op_q));
  assign bmag    = mag(b_q, op_b_signed(op_q));

  // One iteration. Multiply: hi:lo shifts right, multiplier in lo, product
  // accumulates in hi. Divide: hi:lo shifts left, remainder in hi, quotient
  // bits enter lo from the right.
  logic [XLEN:0]   mul_sum, div_rs, div_diff;
  logic [XLEN-1:0] step_hi, step_lo;

  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, amag} : '0);
    div_rs   = {hi_q, lo_q[XLEN-1]};
    div_diff = div_rs - {1'b0, bmag};
    if (op_q[2]) begin
      if (!div_diff[XLEN]) begin
        step_hi = div_diff[XLEN-1:0];
        step_lo = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        step_hi = div_rs[XLEN-1:0];
        step_lo = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  // Sign fix-up on the final iteration's output. A zero divisor makes the
  // magnitude quotient all-ones and the remainder |num1|; only signed DIV
  // needs an override so the sign fix does not disturb the all-ones value.
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   mdu_y;
  logic              a_neg, b_neg;

  always_comb begin
    a_neg    = a_q[XLEN-1];
    b_neg    = b_q[XLEN-1];
    prod     = {step_hi, step_lo};
    prod_fix = prod;
    if (((op_q == OP_MULH) && (a_neg ^ b_neg)) || ((op_q == OP_MULHSU) && a_neg))
      prod_fix = -prod;
    mdu_y = '0;
    case (op_q)
      OP_MUL:                       mdu_y = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: mdu_y = prod_fix[2*XLEN-1:XLEN];
      OP_DIV: begin
        if (b_q == '0) mdu_y = '1;
        else           mdu_y = (a_neg ^ b_neg) ? -step_lo : step_lo;
      end
      OP_DIVU:                      mdu_y = step_lo;
      OP_REM:                       mdu_y = a_neg ? -step_hi : step_hi;
      OP_REMU:                      mdu_y = step_hi;
      default:                      mdu_y = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d = aluop;
          a_d  = num1;
          b_d  = num2;
          if (is_multicycle(aluop)) begin
            state_d = EXEC;
            cnt_d   = CW'(XLEN);
            hi_d    = '0;
            lo_d    = aluop[2] ? in_amag : in_bmag;
          end else begin
            state_d = DONE;
            res_d   = basic_y;
          end
        end
      end
      EXEC: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          res_d   = mdu_y;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign res       = res_q;

endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the operand and result width (legal values: 32, 64).
REQ-002 SHALL have parameter SHW, default $clog2(XLEN), giving the number of shift-amount bits taken from num2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: the request on aluop/num1/num2 is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts a request this cycle.
REQ-007 SHALL have port aluop, input, 5 bits: operation code, encoded per alu_pkg.
REQ-008 SHALL have ports num1 and num2, input, XLEN bits each: the operands.
REQ-009 SHALL have port out_valid, output, 1 bit: res holds a completed result.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer takes res this cycle.
REQ-011 SHALL have port res, output, XLEN bits: the result.

Function
REQ-012 SHALL accept a request on a rising edge where in_valid and in_ready are both 1, and SHALL latch aluop, num1 and num2 at that edge.
REQ-013 SHALL implement the state machine IDLE -> EXEC -> DONE -> IDLE.
 - in_ready = 1 only in IDLE.
 - out_valid = 1 only in DONE.
REQ-014 SHALL support single-cycle ops 0..10 (see table):
 - 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND
 - 5 SLT signed, 6 SLL, 7 SRL, 8 SRA, 9 SLTU, 10 EQ
 - Compare ops (SLT, SLTU, EQ) return 1 or 0, zero-extended to XLEN.
REQ-015 SHALL use only num2[SHW-1:0] as the shift amount for SLL, SRL and SRA.
REQ-016 SHALL handle single-cycle ops as follows: skip EXEC and go IDLE -> DONE, so out_valid is 1 in the cycle after acceptance (latency 1).
REQ-017 SHALL support multi-cycle ops 16..23:
 - 16 MUL (low XLEN bits), 17 MULH (signed x signed), 18 MULHSU, 19 MULHU (high XLEN bits)
 - 20 DIV, 21 DIVU, 22 REM, 23 REMU
REQ-018 SHALL compute multi-cycle ops iteratively, one bit per cycle:
 - multiply by shift-add, divide by restoring division, on magnitudes with the sign fixed at the end;
 - EXEC lasts exactly XLEN cycles;
 - out_valid is 1 exactly XLEN+1 cycles after acceptance, with no exceptions.
REQ-019 SHALL, for divide by zero, return quotient all-ones and remainder num1, with the same fixed latency.
REQ-020 SHALL, for signed overflow (num1 = -2^(XLEN-1), num2 = -1), return DIV = num1 and REM = 0, with the same fixed latency.
REQ-021 SHALL treat an undefined aluop as a single-cycle op with res = 0.
REQ-022 SHALL hold res and out_valid stable in DONE until out_ready = 1, and SHALL leave DONE for IDLE on that edge.
REQ-023 SHALL not start a new request in the DONE cycle in which out_ready = 1; the maximum rate is one single-cycle op per 2 cycles.
REQ-024 SHALL ignore changes on in_valid/aluop/num1/num2 while not in IDLE.

Reset
REQ-025 SHALL, when rst = 1 at a rising edge, set: state IDLE, out_valid 0, res 0, iteration counter 0, all datapath registers 0.
REQ-026 SHALL, when rst arrives in EXEC or DONE, abandon the pending operation with no output; in_ready = 1 in the first cycle after rst deasserts.
REQ-027 SHALL give rst priority over an acceptance or out_ready handshake on the same edge.

Structure
REQ-028 SHALL place the following in package alu_pkg:
 - the 5-bit aluop enum (values above);
 - the state enum {IDLE, EXEC, DONE};
 - a function is_multicycle(aluop).
REQ-029 SHALL place the single-cycle ops in sub-module alu_basic (combinational, XLEN-parametrised); the FSM, counter and mul/div datapath live in alu_mdu.
REQ-030 SHALL size the iteration counter at $clog2(XLEN)+1 bits.

Verification (XLEN=32)
REQ-031 SHALL cover: ADD 0xFFFFFFFF + 1 -> res 0x00000000, out_valid at cycle+1; SRA 0x80000000 by num2 = 0x21 -> 0xC0000000 (shift amount 1).
REQ-032 SHALL cover: MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; both out_valid exactly 33 cycles after acceptance.
REQ-033 SHALL cover: DIV 7 / -2 -> 0xFFFFFFFD; REM 7 % -2 -> 1; DIVU x/0 -> 0xFFFFFFFF; REM x%0 -> x; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
REQ-034 SHALL cover back-pressure: out_ready held 0 for 10 cycles after a MUL 3 x 5 -> res stays 15 and out_valid stays 1, in_ready stays 0; out_ready = 1 -> in_ready = 1 on the next cycle.
REQ-035 SHALL cover: rst asserted 5 cycles into DIV -> out_valid 0, res 0, in_ready 1 after release; a following ADD 2 + 3 -> 5.
REQ-036 SHALL cover: in_valid held 1 with changing operands during EXEC -> none accepted; the result matches the operands latched at acceptance.
